// File: rtl/dualport_fifo_ctrl_pkg.sv
// Shared sizing for the dual-port-RAM FIFO controller: default widths,
// depth derivation and the width of the occupancy count.
package dualport_fifo_ctrl_pkg;

   localparam int AW_DEF = 6;
   localparam int DW_DEF = 16;

   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

   // The count must hold DEPTH in RAM plus one word parked in the RAM's doa latch.
   function automatic int level_width(input int aw);
      return aw + 1;
   endfunction

endpackage

// File: rtl/dualport_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving a 1RW+1W dual-port RAM:
// port B takes pushes, port A reads ahead into the RAM's registered doa latch.
module dualport_fifo_ctrl
   import dualport_fifo_ctrl_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW:0]   level,
   output logic          mem_ena,
   output logic          mem_wea,
   output logic [AW-1:0] mem_addra,
   output logic          mem_enb,
   output logic [AW-1:0] mem_addrb,
   output logic [DW-1:0] mem_dib,
   input  logic [DW-1:0] mem_doa
);

   localparam int            DEPTH    = depth_of(AW);
   localparam int            CW       = level_width(AW);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] mem_cnt_reg, mem_cnt_next;
   logic [CW-1:0] level_reg, level_next;
   logic          out_valid_reg, out_valid_next;
   logic          in_ready_reg, in_ready_next;
   logic          push;
   logic          issue;

   // A word written this cycle only counts towards mem_cnt next cycle, so a
   // read can never target the address being written.
   always_comb begin
      push  = in_valid & in_ready_reg & ~flush;
      issue = (mem_cnt_reg != '0) & (~out_valid_reg | out_ready) & ~flush;
   end

   always_comb begin
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      mem_cnt_next   = mem_cnt_reg;
      out_valid_next = out_valid_reg;

      if (flush) begin
         wr_ptr_next    = '0;
         rd_ptr_next    = '0;
         mem_cnt_next   = '0;
         out_valid_next = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
         end
         if (issue) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
         end
         case ({push, issue})
            2'b10:   mem_cnt_next = mem_cnt_reg + CNT_ONE;
            2'b01:   mem_cnt_next = mem_cnt_reg - CNT_ONE;
            default: mem_cnt_next = mem_cnt_reg;
         endcase
         out_valid_next = issue | (out_valid_reg & ~out_ready);
      end

      in_ready_next = (mem_cnt_next != CNT_FULL);
      level_next    = mem_cnt_next + {{AW{1'b0}}, out_valid_next};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         mem_cnt_reg   <= '0;
         level_reg     <= '0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b1;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         mem_cnt_reg   <= mem_cnt_next;
         level_reg     <= level_next;
         out_valid_reg <= out_valid_next;
         in_ready_reg  <= in_ready_next;
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign level     = level_reg;

   // The RAM's doa latch is the head register; holding ena low freezes it.
   assign out_data  = mem_doa;
   assign mem_ena   = issue;
   assign mem_wea   = 1'b0;
   assign mem_addra = rd_ptr_reg;
   assign mem_enb   = push;
   assign mem_addrb = wr_ptr_reg;
   assign mem_dib   = in_data;

endmodule

// File: doc/dualport_fifo_ctrl.md
Name: dualport_fifo_ctrl

Overview:
- Controller that turns the 64x16 1RW+1W dual-port RAM into a first-word-fall-through FIFO.
- Sits directly upstream of the RAM and drives every RAM control and address pin:
  - port B is the write port (push side);
  - port A is the read port, with wea held at 0.
- The parent ties both RAM clocks (clka, clkb) to clk.
- The RAM's registered doa output is the FIFO output data.

Parameters:
- AW, 6, address width; depth DEPTH = 2**AW = 64.
- DW, 16, data width.

Ports:
- clk  in  1  single clock; drives this block and both RAM ports.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all FIFO state.
- in_valid  in  1  push request.
- in_ready  out  1  FIFO can accept a push.
- in_data  in  DW  push data.
- out_valid  out  1  out_data holds the head entry.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DW  head data; wired straight from mem_doa.
- level  out  AW+1  total entries held (RAM + head); range 0..DEPTH+1.
- mem_ena  out  1  RAM port A enable (read issue).
- mem_wea  out  1  RAM port A write enable; constant 0.
- mem_addra  out  AW  read pointer.
- mem_enb  out  1  RAM port B enable (write).
- mem_addrb  out  AW  write pointer.
- mem_dib  out  DW  equals in_data.
- mem_doa  in  DW  RAM port A registered read data.

Behaviour:
- Reset state (asynchronous): wr_ptr=0, rd_ptr=0, mem_cnt=0, out_valid=0, level=0, in_ready=1.
- Internal state:
  - mem_cnt (AW+1 bits, 0..DEPTH) counts entries written to the RAM and not yet read.
  - The head register is the RAM's own doa latch.
- Push:
  - push = in_valid & in_ready.
  - in_ready = (mem_cnt != DEPTH), a registered flag.
  - mem_enb = push; mem_addrb = wr_ptr.
  - On push, wr_ptr increments and wraps from DEPTH-1 to 0.
- Read issue:
  - issue = (mem_cnt != 0) & (~out_valid | out_ready).
  - mem_ena = issue; mem_addra = rd_ptr.
  - On issue, rd_ptr increments and wraps from DEPTH-1 to 0.
- Output:
  - out_valid(next) = issue | (out_valid & ~out_ready).
  - Read latency is 1 cycle: data issued at cycle t appears on mem_doa and out_data at t+1, with out_valid=1.
  - While out_valid & ~out_ready, mem_ena=0, so doa and out_data stay stable.
- Throughput: one push and one pop per cycle sustained.
- Counter update: mem_cnt(next) = mem_cnt + push - issue. Both in one cycle leaves it unchanged.
- Write-to-read visibility:
  - A word pushed at cycle t can be issued no earlier than t+1, when the RAM already holds it.
  - Same-address read/write collisions therefore never occur.
  - Empty-to-out_valid latency is 2 cycles (push at t, issue at t+1, out_valid at t+2).
- Full: with mem_cnt=DEPTH, in_ready=0 and in_valid is ignored. level can reach DEPTH+1 (RAM full plus head).
- Empty: with mem_cnt=0, mem_ena=0. If out_valid & out_ready, out_valid drops next cycle.
- Flush (priority over push and pop):
  - Next state equals reset state.
  - mem_enb and mem_ena are forced to 0 in the flush cycle.
  - The push in that cycle is dropped.
- level is registered and equals mem_cnt + out_valid.
- Reset or flush mid-burst: RAM contents are left as-is. Only pointers and flags clear, so stale data is never presented.
- Protocol: in_data must stay stable while in_valid & ~in_ready. out_data is stable while out_valid & ~out_ready.

Decomposition:
- Shared package: AW/DW defaults, DEPTH derivation, and the level width function.
- No sub-module. The RAM is instantiated by the parent alongside this block; pointer and counter logic stays flat.

Test Plan:
- Reset, then push 0x1111 at cycle 0 only → mem_enb=1 with addrb=0 at cycle 0; mem_ena=1 with addra=0 at cycle 1; out_valid=1, out_data=0x1111, level=1 at cycle 2.
- Push 0x0000..0x0040 (65 words) with out_ready=0 → 65 accepted, in_ready=0, level=65; 66th in_valid ignored. Then out_ready=1 → 65 pops in order, one per cycle, ending with level=0.
- Continuous push and pop of an incrementing pattern for 200 cycles → one transfer per cycle after 2-cycle fill; pointers wrap through 63→0 cleanly; output matches order.
- Hold out_ready=0 for 5 cycles with out_valid=1 → mem_ena=0 and out_data constant throughout; the next word appears the cycle after out_ready rises.
- Flush with level=10 while in_valid=1 → next cycle level=0, out_valid=0, pointers 0; the pushed word is absent. A following push 0xBEEF is the next word popped.
- Assert rst mid-stream between clock edges → outputs clear immediately, before the next edge; operation resumes correctly after release.
